mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported unified memory between instruction fetch (IR load path) and data
//  load/store (LD/ST path) of the multi-cycle CPU. Serialises requests, drives the memory for
//  MEM_LAT cycles per access and returns read data with a one-cycle ack.
//  Sits between the controller/datapath and the memory; the controller stalls until ack.
// PARAMETERS
//  ADDR_W   8   address width
//  DATA_W   16  data width
//  MEM_LAT  2   cycles mem_addr/mem_en are held per access; legal range >=1
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       reset, asynchronous, active-low
//  fetch_req    in   1       fetch request, held until fetch_ack
//  fetch_addr   in   ADDR_W  fetch address (PC)
//  fetch_ack    out  1       one-cycle pulse: fetch done, fetch_rdata valid
//  fetch_rdata  out  DATA_W  fetched instruction, held until next fetch_ack
//  data_req     in   1       load/store request, held until data_ack
//  data_we      in   1       1 = store, 0 = load
//  data_addr    in   ADDR_W  data address
//  data_wdata   in   DATA_W  store data
//  data_ack     out  1       one-cycle pulse: data access done
//  data_rdata   out  DATA_W  load data, held until next data_ack
//  mem_en       out  1       memory enable
//  mem_we       out  1       memory write strobe (only with mem_en, data owner, data_we)
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, valid on last ACCESS cycle
//  busy         out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, count=0, owner=DATA, all acks/mem_en/mem_we/busy=0,
//    mem_addr/mem_wdata/fetch_rdata/data_rdata=0, round-robin pointer = data-first.
//  - FSM IDLE -> ACCESS -> ACK -> IDLE.
//  - IDLE: on any req, latch owner, addr, we, wdata (registered); go ACCESS, count=MEM_LAT-1.
//  - ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata from latched copy, stable all MEM_LAT cycles;
//    count decrements; when count==0 capture mem_rdata into owner's rdata (loads/fetches
//    only; stores leave data_rdata unchanged) and go ACK.
//  - ACK: owner's ack=1 for exactly one cycle, mem_en=0; go IDLE.
//  - Latency: req sampled in IDLE at cycle 0 -> mem_en cycles 1..MEM_LAT -> ack at MEM_LAT+1.
//    Back-to-back accesses: next grant sampled in the cycle after ack; period MEM_LAT+2.
//  - Both req in IDLE same cycle: data wins (fixed priority) unless ROUND_ROBIN_EN.
//  - Req dropped mid-access: access still completes and ack still pulses; inputs changed
//    after latch have no effect. Never both acks high in one cycle.
//  - fetch owner: mem_we=0 always. MEM_LAT=1: single ACCESS cycle, count width >=1 bit.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: on simultaneous requests grant goes to the requester not served
//    last; pointer updates at each grant. Undefined: fixed data-over-fetch priority, no pointer.
// STRUCTURE
//  cpu_pkg: arb_state_t enum {IDLE, ACCESS, ACK}; OWNER_FETCH/OWNER_DATA constants.
//  Sub-module arb_wait_counter: loadable down-counter (load MEM_LAT-1, dec, zero flag).
// TESTING (MEM_LAT=2)
//  - fetch_req=1, fetch_addr=0x10, mem holds 0xA5A5 -> mem_en cycles 1-2 addr 0x10,
//    fetch_ack at cycle 3, fetch_rdata=0xA5A5.
//  - data_req, data_we=1, addr 0x20, wdata 0x1234 -> mem_we=1 cycles 1-2, data_ack cycle 3;
//    readback load of 0x20 returns 0x1234; data_rdata unchanged by the store.
//  - fetch_req and data_req both high in IDLE -> data served first, fetch ack 4 cycles
//    later; with ROUND_ROBIN_EN and data served last, fetch served first.
//  - rst_n low during ACCESS -> mem_en, acks, busy 0 immediately; no ack after release.
//  - fetch_req dropped after cycle 1 -> access completes, fetch_ack at cycle 3.
//  - MEM_LAT=1 build: fetch ack at cycle 2, mem_en high exactly one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE -> ACCESS -> ACK -> IDLE)
//   OWNER_FETCH  : access owner is the instruction fetch port
//   OWNER_DATA   : access owner is the load/store port
//   pick_owner() : grant decision for the requests seen in IDLE
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    // Returns the port to serve. Single requests are served directly. For
    // simultaneous requests, data wins unless round-robin is active, in
    // which case the port that was not served last wins.
    function automatic logic pick_owner(
        input logic fetch_req,
        input logic data_req,
        input logic rr_on,
        input logic last_served
    );
        logic owner;
        if (fetch_req && data_req) begin
            if (rr_on) begin
                owner = (last_served == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
            end else begin
                owner = OWNER_DATA;
            end
        end else if (data_req) begin
            owner = OWNER_DATA;
        end else begin
            owner = OWNER_FETCH;
        end
        return owner;
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that times the memory access phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes precedence over dec)
//   dec        : decrement by one, saturating at zero
//   load_val   : value loaded at the start of an access
//   count      : current count
//   zero       : count has reached zero (last access cycle)
module arb_wait_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count register: load has priority, decrement never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != {W{1'b0}})) begin
            count <= count - ONE;
        end else begin
            count <= count;
        end
    end

    assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// data load/store. Each access latches the winning request, holds
// mem_en/mem_addr/mem_we/mem_wdata for MEM_LAT cycles, then pulses the
// owner's ack for one cycle with read data already captured.
//
// Optional feature: define ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise data has fixed priority over fetch.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_req/addr             fetch request (held until fetch_ack)
//   fetch_ack/rdata            one-cycle done pulse, instruction word (held)
//   data_req/we/addr/wdata     load/store request (held until data_ack)
//   data_ack/rdata             one-cycle done pulse, load data (held)
//   mem_en/we/addr/wdata       memory drive, registered
//   mem_rdata                  memory read data, valid on last access cycle
//   busy                       arbiter not idle
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // At least one bit even when MEM_LAT is 1 (counter then only holds 0).
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state_r;
    arb_state_t       state_nx_s;
    logic             owner_r;
    logic             grant_s;
    logic             grant_owner_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic             capture_s;
    logic             last_served_s;
    logic [CNT_W-1:0] cnt_s;

`ifdef ROUND_ROBIN_EN
    localparam logic RR_ON = 1'b1;
    logic last_served_r;

    // Remembers which port won the most recent grant; reset makes data first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served_r <= OWNER_FETCH;
        end else if (grant_s) begin
            last_served_r <= grant_owner_s;
        end else begin
            last_served_r <= last_served_r;
        end
    end

    assign last_served_s = last_served_r;
`else
    localparam logic RR_ON = 1'b0;
    assign last_served_s = OWNER_FETCH;
`endif

    arb_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (CNT_LOAD),
        .count    (cnt_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and grant decision.
    always_comb begin
        state_nx_s    = state_r;
        grant_s       = 1'b0;
        grant_owner_s = owner_r;
        cnt_load_s    = 1'b0;
        cnt_dec_s     = 1'b0;
        capture_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (fetch_req || data_req) begin
                    grant_s       = 1'b1;
                    grant_owner_s = pick_owner(fetch_req, data_req, RR_ON, last_served_s);
                    cnt_load_s    = 1'b1;
                    state_nx_s    = ACCESS;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_zero_s) begin
                    capture_s  = 1'b1;
                    state_nx_s = ACK;
                end else begin
                    cnt_dec_s  = 1'b1;
                    state_nx_s = ACCESS;
                end
            end
            ACK: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, owner and status outputs derived from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= OWNER_DATA;
            busy    <= 1'b0;
            mem_en  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            owner_r <= grant_s ? grant_owner_s : owner_r;
            busy    <= (state_nx_s != IDLE);
            mem_en  <= (state_nx_s == ACCESS);
        end
    end

    // Latched request copy driven onto the memory; later request changes
    // are ignored until the next grant. mem_we only accompanies mem_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_we    <= 1'b0;
        end else if (grant_s) begin
            mem_addr  <= (grant_owner_s == OWNER_DATA) ? data_addr : fetch_addr;
            mem_wdata <= data_wdata;
            mem_we    <= (grant_owner_s == OWNER_DATA) && data_we;
        end else if (state_nx_s != ACCESS) begin
            mem_we    <= 1'b0;
        end else begin
            mem_we    <= mem_we;
        end
    end

    // Acks pulse in the ACK cycle; read data is captured on the last access
    // cycle. A store (mem_we still high) leaves data_rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ack   <= 1'b0;
            data_ack    <= 1'b0;
            fetch_rdata <= {DATA_W{1'b0}};
            data_rdata  <= {DATA_W{1'b0}};
        end else begin
            fetch_ack <= capture_s && (owner_r == OWNER_FETCH);
            data_ack  <= capture_s && (owner_r == OWNER_DATA);
            if (capture_s && (owner_r == OWNER_FETCH)) begin
                fetch_rdata <= mem_rdata;
            end else begin
                fetch_rdata <= fetch_rdata;
            end
            if (capture_s && (owner_r == OWNER_DATA) && !mem_we) begin
                data_rdata <= mem_rdata;
            end else begin
                data_rdata <= data_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2): directed cases then
// randomized request pairs checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam logic M_FETCH = 1'b0;
    localparam logic M_DATA  = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [7:0]  data_addr;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_ack    (data_ack),
        .data_rdata  (data_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial memory content: a fixed function of the address, 0x10 = 0xA5A5.
    function automatic logic [15:0] seed_word(input logic [7:0] a);
        logic [15:0] w;
        if (a == 8'h10) begin
            w = 16'hA5A5;
        end else begin
            w = {a, ~a} ^ 16'h3C5A;
        end
        return w;
    endfunction

    // Memory device: written words override the seeded content.
    logic [15:0] dev_mem   [256];
    logic        dev_valid [256];
    logic        tb_ready;

    always @(posedge clk) begin
        if (!tb_ready) begin
            for (int i = 0; i < 256; i++) dev_valid[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            dev_mem[mem_addr]   <= mem_wdata;
            dev_valid[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = dev_valid[mem_addr] ? dev_mem[mem_addr] : seed_word(mem_addr);

    // Reference model state.
    logic [15:0] ref_mem [256];
    logic        fpend, dpend;
    logic [7:0]  m_faddr, m_daddr;
    logic        m_dwe;
    logic [15:0] m_dwdata;
    logic [15:0] exp_frdata, exp_drdata;
    logic        last_served;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        fetch_req  = fpend;
        fetch_addr = m_faddr;
        data_req   = dpend;
        data_we    = m_dwe;
        data_addr  = m_daddr;
        data_wdata = m_dwdata;
    endtask

    // Serves one pending request starting from an IDLE cycle (cycle 0).
    // mode 0: inputs stable; 1: winner inputs scrambled after cycle 1;
    // 2: scrambled and winner request dropped after cycle 1.
    task automatic serve(input int mode);
        logic        win;
        logic [7:0]  a;
        logic        we;
        logic [15:0] wd;
`ifdef ROUND_ROBIN_EN
        if (fpend && dpend) win = (last_served == M_DATA) ? M_FETCH : M_DATA;
`else
        if (fpend && dpend) win = M_DATA;
`endif
        else if (dpend) win = M_DATA;
        else win = M_FETCH;
        last_served = win;
        a  = (win == M_DATA) ? m_daddr : m_faddr;
        we = (win == M_DATA) ? m_dwe : 1'b0;
        wd = m_dwdata;
        for (int c = 1; c <= MEM_LAT; c++) begin
            tick();
            check_eq("acc_mem_en", mem_en, 1'b1);
            check_eq("acc_addr", mem_addr, a);
            check_eq("acc_we", mem_we, we);
            if (we) check_eq("acc_wdata", mem_wdata, wd);
            check_eq("acc_busy", busy, 1'b1);
            check_eq("acc_acks", {fetch_ack, data_ack}, 2'b00);
            if (c == 1 && mode != 0) begin
                if (win == M_DATA) begin
                    data_addr  = 8'($urandom);
                    data_wdata = 16'($urandom);
                    data_we    = 1'($urandom);
                    if (mode == 2) begin data_req = 1'b0; dpend = 1'b0; end
                end else begin
                    fetch_addr = 8'($urandom);
                    if (mode == 2) begin fetch_req = 1'b0; fpend = 1'b0; end
                end
            end
        end
        tick();
        if (win == M_FETCH) exp_frdata = ref_mem[a];
        else if (!we) exp_drdata = ref_mem[a];
        else ref_mem[a] = wd;
        check_eq("ack_fetch", fetch_ack, win == M_FETCH);
        check_eq("ack_data", data_ack, win == M_DATA);
        check_eq("ack_mem_en", mem_en, 1'b0);
        check_eq("ack_busy", busy, 1'b1);
        check_eq("fetch_rdata", fetch_rdata, exp_frdata);
        check_eq("data_rdata", data_rdata, exp_drdata);
        if (win == M_FETCH) begin fetch_req = 1'b0; fpend = 1'b0; end
        else begin data_req = 1'b0; dpend = 1'b0; end
        tick();
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_acks", {fetch_ack, data_ack}, 2'b00);
        check_eq("idle_mem_en", mem_en, 1'b0);
    endtask

    initial begin
        tb_ready = 1'b0;
        rst_n = 1'b0;
        fpend = 1'b0; dpend = 1'b0;
        m_faddr = 8'h00; m_daddr = 8'h00; m_dwe = 1'b0; m_dwdata = 16'h0000;
        drive_reqs();
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(8'(i));
        exp_frdata = 16'h0000; exp_drdata = 16'h0000;
        last_served = M_FETCH;
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_acks", {fetch_ack, data_ack}, 2'b00);
        check_eq("rst_mem_addr", mem_addr, 8'h00);
        check_eq("rst_rdata", {fetch_rdata, data_rdata}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        tb_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fetch from 0x10 (0xA5A5).
        fpend = 1'b1; m_faddr = 8'h10; drive_reqs();
        serve(0);
        check_eq("fetch_a5a5", fetch_rdata, 16'hA5A5);

        // Store 0x1234 to 0x20, then read it back.
        dpend = 1'b1; m_daddr = 8'h20; m_dwe = 1'b1; m_dwdata = 16'h1234; drive_reqs();
        serve(0);
        check_eq("store_keeps_rdata", data_rdata, 16'h0000);
        dpend = 1'b1; m_dwe = 1'b0; drive_reqs();
        serve(0);
        check_eq("load_back", data_rdata, 16'h1234);

        // Simultaneous requests: two back-to-back accesses.
        fpend = 1'b1; m_faddr = 8'h05; dpend = 1'b1; m_daddr = 8'h06; drive_reqs();
        serve(0);
        serve(0);

        // Fetch request dropped after cycle 1.
        fpend = 1'b1; m_faddr = 8'h11; drive_reqs();
        serve(2);

        // Reset during ACCESS.
        fpend = 1'b1; m_faddr = 8'h30; drive_reqs();
        tick();
        check_eq("pre_rst_mem_en", mem_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mem_en", mem_en, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_acks", {fetch_ack, data_ack}, 2'b00);
        check_eq("arst_rdata", {fetch_rdata, data_rdata}, 32'h0);
        fpend = 1'b0; drive_reqs();
        exp_frdata = 16'h0000; exp_drdata = 16'h0000; last_served = M_FETCH;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("post_rst_no_ack", {fetch_ack, data_ack, busy}, 3'b000);
        end

        // Randomized request pairs.
        for (int it = 0; it < 80; it++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            fpend    = sel[0];
            dpend    = sel[1];
            m_faddr  = 8'($urandom_range(0, 15));
            m_daddr  = 8'($urandom_range(0, 15));
            m_dwe    = 1'($urandom);
            m_dwdata = 16'($urandom);
            drive_reqs();
            for (int k = 0; k < 2 && (fpend || dpend); k++) begin
                serve(int'($urandom_range(0, 2)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
